neuron_accumulator: RTL
=======================

NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

Interface
REQ-001 Parameter N_TERMS, default 4, SHALL set the number of products summed per result (legal range 2..16).
REQ-002 Parameter ACC_W, default 8, SHALL set the accumulator and out_sum width in bits (legal range 4..16).
REQ-003 Parameter THRESH, default 9, SHALL set the unsigned firing threshold compared against out_sum.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 clear  input  1  synchronous abort of the partial sum in progress.
REQ-008 in_valid  input  1  in_prod holds a valid product this cycle.
REQ-009 in_ready  output  1  block accepts a product this cycle.
REQ-010 in_prod  input  4  unsigned 2x2-bit product from the upstream multiplier, values 0..9.
REQ-011 out_valid  output  1  out_sum, out_fire and overflow are valid.
REQ-012 out_ready  input  1  downstream consumes the result this cycle.
REQ-013 out_sum  output  ACC_W  saturated sum of N_TERMS products.
REQ-014 out_fire  output  1  out_sum >= THRESH.
REQ-015 overflow  output  1  saturation occurred during this result.

Function
REQ-016 A product SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-017 Two-state FSM: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-018 In ACCUM, each accepted product SHALL be added to acc, and term count cnt SHALL increment.
REQ-019 Accepting the N_TERMS-th product SHALL move the FSM to HOLD, with out_valid=1 on the next cycle (1-cycle latency from the final accept).
REQ-020 Addition SHALL be unsigned with saturation at 2^ACC_W-1; any saturating add SHALL set a sticky ovf flag for the current result.
REQ-021 In HOLD, out_sum, out_fire and overflow SHALL stay stable until out_ready=1.
REQ-022 HOLD with out_ready=1 SHALL return the FSM to ACCUM next cycle with acc=0, cnt=0 and ovf=0.
REQ-023 In HOLD, in_prod SHALL be ignored regardless of in_valid; there is no input/output overlap, so throughput is N_TERMS+1 cycles per result minimum.
REQ-024 out_fire SHALL be derived combinationally from the registered out_sum.
REQ-025 In ACCUM, clear=1 SHALL zero acc, cnt and ovf next cycle; clear SHALL win over a simultaneous accept, and that product is discarded.
REQ-026 In HOLD, clear SHALL have no effect; the pending result is never dropped.
REQ-027 in_prod values above 9 are out of contract; they SHALL still be summed arithmetically, with no checking.
REQ-028 cnt SHALL never exceed N_TERMS-1 in ACCUM; its width is clog2(N_TERMS).

Reset
REQ-029 rst=1 SHALL, at the next rising edge, force the FSM to ACCUM with acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0 and overflow=0.
REQ-030 rst SHALL override clear, in_valid and out_ready, and SHALL discard any partial sum or pending result mid-operation.
REQ-031 in_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-032 The state encoding (ACCUM=1'b0, HOLD=1'b1) and the maximum product constant (PROD_MAX=9) SHALL live in the shared neural-network header/package.
REQ-033 One sub-module, sat_adder (ACC_W-bit acc plus 4-bit operand, saturated sum plus sat flag), SHALL hold the arithmetic; the FSM and registers stay in neuron_accumulator.

Verification
REQ-034 Defaults; products 6,2,0,3 on consecutive cycles, out_ready=1 -> out_valid one cycle after the 4th accept, out_sum=11, out_fire=1, overflow=0.
REQ-035 Products 1,1,1,1 -> out_sum=4, out_fire=0; in_ready=0 for exactly one cycle (the HOLD cycle).
REQ-036 Backpressure: products 9,9,9,9 with out_ready=0 for 5 cycles -> out_sum=36 held stable, in_ready=0 throughout; release -> ACCUM, acc=0.
REQ-037 ACC_W=5: products 9,9,9,9 -> out_sum=31, overflow=1, out_fire=1; the next result 1,1,1,1 -> out_sum=4, overflow=0.
REQ-038 Clear: products 4,4, then clear=1 with in_valid=1 and in_prod=9, then 2,2,2,2 -> out_sum=8 (the 9 is discarded).
REQ-039 Reset: rst pulsed after 2 products, and separately during HOLD -> out_valid=0 next cycle, in_ready=1, and the following 4 products give an independent correct sum.

Source files
------------

// File: rtl/neuron_accumulator_pkg.sv
// Shared neural-network definitions: FSM state encoding and product range.
`default_nettype none

package neuron_accumulator_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int unsigned PROD_MAX = 9;
  // Width of one 2x2-bit product, derived from its largest legal value.
  localparam int unsigned PROD_W = $clog2(PROD_MAX + 1);

endpackage

`default_nettype wire

// File: rtl/neuron_accumulator_sat_adder.sv
// Unsigned accumulator-plus-product adder saturating at 2^ACC_W-1.
`default_nettype none

module sat_adder
  import neuron_accumulator_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] operand,
  output logic [ACC_W-1:0]  sum,
  output logic              sat
);

  // One guard bit catches the carry; ACC_W >= PROD_W keeps it sufficient.
  logic [ACC_W:0] full;

  assign full = {1'b0, acc} + (ACC_W + 1)'(operand);
  assign sat  = full[ACC_W];
  assign sum  = sat ? {ACC_W{1'b1}} : full[ACC_W-1:0];

endmodule

`default_nettype wire

// File: rtl/neuron_accumulator.sv
// Sums N_TERMS products per result with saturation, then holds the result
// until downstream accepts it; fires when the sum reaches THRESH.
`default_nettype none

module neuron_accumulator
  import neuron_accumulator_pkg::*;
#(
  parameter int          N_TERMS = 4,
  parameter int          ACC_W   = 8,
  parameter int unsigned THRESH  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_fire,
  output logic              overflow
);

  localparam int CNT_W = $clog2(N_TERMS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  state_t           state, state_n;
  logic [ACC_W-1:0] acc, acc_n, add_sum;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             ovf, ovf_n, add_sat;

  sat_adder #(
    .ACC_W(ACC_W)
  ) u_sat_adder (
    .acc    (acc),
    .operand(in_prod),
    .sum    (add_sum),
    .sat    (add_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      cnt   <= cnt_n;
      ovf   <= ovf_n;
    end
  end

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    cnt_n     = cnt;
    ovf_n     = ovf;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        // Clear takes priority; a product offered alongside it is dropped.
        if (clear) begin
          acc_n = '0;
          cnt_n = '0;
          ovf_n = 1'b0;
        end else if (in_valid) begin
          acc_n = add_sum;
          ovf_n = ovf | add_sat;
          if (cnt == LAST) begin
            cnt_n   = '0;
            state_n = HOLD;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_n   = '0;
          cnt_n   = '0;
          ovf_n   = 1'b0;
          state_n = ACCUM;
        end
      end
      default: state_n = ACCUM;
    endcase
  end

  // The accumulator doubles as the result register while in HOLD.
  assign out_sum  = acc;
  assign overflow = ovf;
  assign out_fire = (32'(acc) >= THRESH);

endmodule

`default_nettype wire
